// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache: FSM encodings,
// derived address-field widths and the word/byte lane helpers.
package dcache_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITEBACK  = 3'd1;
    localparam logic [2:0] S_REFILL     = 3'd2;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
    localparam logic [2:0] S_FLUSH_WB   = 3'd4;
    localparam logic [2:0] S_FLUSH_INV  = 3'd5;

    function automatic int off_w_f(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_w_f(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w_f(input int addr_w, input int line_w, input int num_sets);
        return addr_w - idx_w_f(num_sets) - off_w_f(line_w);
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic        byte_acc,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        res = old_word;
        if (byte_acc) begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                2'd3:    res[31:24] = wdata[7:0];
                default: res        = old_word;
            endcase
        end else begin
            res = wdata;
        end
        return res;
    endfunction

    function automatic logic [31:0] extract_word(input logic [31:0] word,
                                                 input logic        byte_acc,
                                                 input logic [1:0]  lane);
        logic [31:0] res;
        if (byte_acc) begin
            case (lane)
                2'd0:    res = {24'd0, word[7:0]};
                2'd1:    res = {24'd0, word[15:8]};
                2'd2:    res = {24'd0, word[23:16]};
                2'd3:    res = {24'd0, word[31:24]};
                default: res = 32'd0;
            endcase
        end else begin
            res = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty/data arrays with a combinational hit,
// a full-line fill port, a word/byte store-merge port and dirty clearing.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int LINE_W = 128,
    parameter int TAG_W  = 26,
    parameter int IDX_W  = 2,
    parameter int WSEL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    output logic              hit,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  line_tag,
    output logic [LINE_W-1:0] line_data,
    input  logic              fill_en,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              store_en,
    input  logic [WSEL_W-1:0] store_word,
    input  logic [31:0]       store_data,
    input  logic              store_byte,
    input  logic [1:0]        store_lane,
    input  logic              clean_en,
    input  logic              inv_all
);
    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [LINE_W-1:0] data_q [SETS];
    logic [LINE_W-1:0] data_d [SETS];

    assign valid     = valid_q[idx];
    assign dirty     = dirty_q[idx];
    assign line_tag  = tag_q[idx];
    assign line_data = data_q[idx];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);

    // Next-state of the arrays; invalidate-all outranks fill, store and clean.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inv_all) begin
            valid_d = '0;
            dirty_d = '0;
        end else if (fill_en) begin
            data_d[idx]  = fill_data;
            tag_d[idx]   = tag;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end else if (store_en) begin
            data_d[idx][store_word*32 +: 32] =
                merge_word(data_q[idx][store_word*32 +: 32], store_data, store_byte, store_lane);
            dirty_d[idx] = 1'b1;
        end else if (clean_en) begin
            dirty_d[idx] = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/data_cache_assoc.sv
// Write-back, write-allocate set-associative data cache (1 or 2 ways, LRU)
// with a miss FSM, write-back-then-invalidate flush and a req/ack line port.
module data_cache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LINE_W   = 128,
    parameter int NUM_SETS = 4,
    parameter int WAYS     = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic                             byte_access,
    input  logic [ADDR_W-1:0]                address,
    input  logic [DATA_W-1:0]                writedata,
    output logic [DATA_W-1:0]                readdata,
    output logic                             stall,
    output logic                             flush_done,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-off_w_f(LINE_W)-1:0] mem_addr,
    output logic [LINE_W-1:0]                mem_wdata,
    input  logic [LINE_W-1:0]                mem_rdata,
    input  logic                             mem_ack
);
    localparam int OFF_W  = off_w_f(LINE_W);
    localparam int IDX_W  = idx_w_f(NUM_SETS);
    localparam int TAG_W  = tag_w_f(ADDR_W, LINE_W, NUM_SETS);
    localparam int WSEL_W = OFF_W - 2;

    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [WSEL_W-1:0] word_sel;
    logic              req;

    assign addr_idx = address[OFF_W+IDX_W-1:OFF_W];
    assign addr_tag = address[ADDR_W-1:OFF_W+IDX_W];
    assign word_sel = address[OFF_W-1:2];
    assign req      = mem_read | mem_write;

    logic [2:0]          state_q, state_d;
    logic                victim_q, victim_d, scan_way_q, scan_way_d;
    logic [IDX_W-1:0]    scan_set_q, scan_set_d;
    logic                flush_pend_q, flush_pend_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;

    logic [WAYS-1:0]   hit_s, valid_s, dirty_s, fill_en_s, store_en_s, clean_en_s;
    logic [TAG_W-1:0]  ltag_s  [WAYS];
    logic [LINE_W-1:0] ldata_s [WAYS];
    logic              inv_all_s, in_flush_s, hit_way_s, vict_s, sel_way_s, stall_s;
    logic [IDX_W-1:0]  way_idx_s;
    logic [DATA_W-1:0] hit_word_s;

    assign in_flush_s = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB) ||
                        (state_q == S_FLUSH_INV);
    assign way_idx_s  = in_flush_s ? scan_set_q : addr_idx;
    assign hit_way_s  = (WAYS == 2) ? hit_s[WAYS-1] : 1'b0;
    assign sel_way_s  = in_flush_s ? scan_way_q : victim_q;
    assign mem_wdata  = ldata_s[sel_way_s];
    assign hit_word_s = ldata_s[hit_way_s][word_sel*DATA_W +: DATA_W];
    assign stall      = stall_s & ~reset;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way #(
            .LINE_W(LINE_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .WSEL_W(WSEL_W)
        ) u_way (
            .clk(clk), .rst(reset), .idx(way_idx_s), .tag(addr_tag),
            .hit(hit_s[w]), .valid(valid_s[w]), .dirty(dirty_s[w]),
            .line_tag(ltag_s[w]), .line_data(ldata_s[w]),
            .fill_en(fill_en_s[w]), .fill_data(mem_rdata),
            .store_en(store_en_s[w]), .store_word(word_sel), .store_data(writedata),
            .store_byte(byte_access), .store_lane(address[1:0]),
            .clean_en(clean_en_s[w]), .inv_all(inv_all_s)
        );
    end

    // Victim: lowest invalid way first, else the LRU way of the set.
    always_comb begin
        vict_s = 1'b0;
        if (!valid_s[0]) begin
            vict_s = 1'b0;
        end else if (WAYS == 2 && !valid_s[WAYS-1]) begin
            vict_s = 1'b1;
        end else if (WAYS == 2) begin
            vict_s = lru_q[addr_idx];
        end else begin
            vict_s = 1'b0;
        end
    end

    // Load data is only driven on an IDLE hit so a refill never leaks through.
    always_comb begin
        if (state_q == S_IDLE && req && (|hit_s)) begin
            readdata = extract_word(hit_word_s, byte_access, address[1:0]);
        end else begin
            readdata = '0;
        end
    end

    // Miss / flush FSM with the memory handshake decoded from the state.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        scan_set_d   = scan_set_q;
        scan_way_d   = scan_way_q;
        flush_pend_d = flush_pend_q;
        lru_d        = lru_q;
        stall_s      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        fill_en_s    = '0;
        store_en_s   = '0;
        clean_en_s   = '0;
        inv_all_s    = 1'b0;
        flush_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush || flush_pend_q) begin
                    stall_s      = 1'b1;
                    flush_pend_d = 1'b0;
                    scan_set_d   = '0;
                    scan_way_d   = 1'b0;
                    state_d      = S_FLUSH_SCAN;
                end else if (req && (|hit_s)) begin
                    store_en_s[hit_way_s] = mem_write;
                    if (WAYS == 2) begin
                        lru_d[addr_idx] = ~hit_way_s;
                    end else begin
                        lru_d = '0;
                    end
                end else if (req) begin
                    stall_s  = 1'b1;
                    victim_d = vict_s;
                    state_d  = (valid_s[vict_s] && dirty_s[vict_s]) ? S_WRITEBACK : S_REFILL;
                end else begin
                    stall_s = 1'b0;
                end
            end
            S_WRITEBACK: begin
                stall_s      = 1'b1;
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = {ltag_s[victim_q], addr_idx};
                flush_pend_d = flush_pend_q | flush;
                if (mem_ack) begin
                    clean_en_s[victim_q] = 1'b1;
                    state_d              = S_REFILL;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_REFILL: begin
                stall_s      = 1'b1;
                mem_req      = 1'b1;
                mem_addr     = address[ADDR_W-1:OFF_W];
                flush_pend_d = flush_pend_q | flush;
                if (mem_ack) begin
                    fill_en_s[victim_q] = 1'b1;
                    if (WAYS == 2) begin
                        lru_d[addr_idx] = ~victim_q;
                    end else begin
                        lru_d = '0;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_FLUSH_SCAN: begin
                stall_s = 1'b1;
                if (valid_s[scan_way_q] && dirty_s[scan_way_q]) begin
                    state_d = S_FLUSH_WB;
                end else if (scan_set_q == IDX_W'(NUM_SETS - 1) && scan_way_q == 1'(WAYS - 1)) begin
                    state_d = S_FLUSH_INV;
                end else if (scan_way_q == 1'(WAYS - 1)) begin
                    scan_way_d = 1'b0;
                    scan_set_d = scan_set_q + 1'b1;
                end else begin
                    scan_way_d = 1'b1;
                end
            end
            S_FLUSH_WB: begin
                stall_s  = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {ltag_s[scan_way_q], scan_set_q};
                if (mem_ack) begin
                    clean_en_s[scan_way_q] = 1'b1;
                    state_d                = S_FLUSH_SCAN;
                end else begin
                    state_d = S_FLUSH_WB;
                end
            end
            S_FLUSH_INV: begin
                stall_s    = 1'b1;
                inv_all_s  = 1'b1;
                lru_d      = '0;
                flush_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            victim_q     <= 1'b0;
            scan_set_q   <= '0;
            scan_way_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            scan_set_q   <= scan_set_d;
            scan_way_q   <= scan_way_d;
            flush_pend_q <= flush_pend_d;
            lru_q        <= lru_d;
        end
    end

endmodule

// File: doc/data_cache_assoc.md
Name: data_cache_assoc

Overview:
Parametrised write-back, write-allocate data cache between the core's MEM stage and the line-wide memory port. It generalises the direct-mapped cache to NUM_SETS sets × WAYS ways (1 or 2) with LRU replacement and byte/word stores. It uses an explicit miss FSM and a single req/ack memory handshake. Flush writes back every dirty line before invalidating; it does not discard dirty data.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, CPU word width
LINE_W, 128, line width in bits; OFF_W = log2(LINE_W/8)
NUM_SETS, 4, sets, power of two; IDX_W = log2(NUM_SETS); TAG_W = ADDR_W-IDX_W-OFF_W
WAYS, 2, associativity, legal values 1 or 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  one-cycle pulse: write back all dirty lines, then invalidate all
mem_read  in  1  CPU load request
mem_write  in  1  CPU store request
byte_access  in  1  1 = byte access (address[1:0] selects lane), 0 = word access (address[1:0] ignored)
address  in  ADDR_W  byte address
writedata  in  DATA_W  store data; byte stores use [7:0]
readdata  out  DATA_W  load data; byte loads are zero-extended
stall  out  1  hold the pipeline; the request must be held stable while high
flush_done  out  1  one-cycle pulse when flush completes
mem_req  out  1  memory request valid
mem_we  out  1  1 = line writeback, 0 = line refill
mem_addr  out  ADDR_W-OFF_W  line address
mem_wdata  out  LINE_W  writeback data
mem_rdata  in  LINE_W  refill data, valid when mem_ack=1 and mem_we=0
mem_ack  in  1  request accepted or completed

Behaviour:
- Reset (async): state=IDLE; all valid, dirty and LRU bits = 0; stall, mem_req, mem_we and flush_done = 0; mem_addr = 0; readdata = 0; pending flush cleared. Takes effect immediately, including mid-refill. A partially received line is never marked valid.
- Address split: offset=[OFF_W-1:0], index=[OFF_W+IDX_W-1:OFF_W], tag=upper TAG_W bits.
- Simultaneous mem_read and mem_write: treated as a write.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB, FLUSH_INV.
- IDLE, hit (valid && tag match in any way):
  - Load: readdata is combinational the same cycle; stall=0.
  - Store: merges the byte or word into the line at the clock edge and sets dirty.
  - Both: update LRU so the hit way becomes MRU.
- IDLE, miss: stall=1 combinationally in the same cycle.
  - Victim = lowest-numbered invalid way; otherwise the LRU way (WAYS=1: way 0).
  - Victim valid and dirty → WRITEBACK; otherwise → REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim line.
  - On mem_ack: clear victim dirty → REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr=address[ADDR_W-1:OFF_W].
  - On mem_ack: write mem_rdata into the victim way, set tag, valid=1, dirty=0, make it MRU → IDLE.
  - The next cycle re-looks-up and hits; a store merges at that point.
- Memory handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable until the cycle mem_ack=1. mem_req drops the following cycle (state change), so there are no back-to-back duplicate requests. mem_ack is ignored when mem_req=0.
- Miss penalty: clean miss = ack latency + 1 cycles of stall; dirty miss = 2 handshakes + 1.
- Flush:
  - Accepted in IDLE; stall=1 from the flush cycle until flush_done.
  - Flush arriving during WRITEBACK/REFILL is latched and serviced on return to IDLE, before the held CPU request.
  - FLUSH_SCAN walks (set 0, way 0), (set 0, way 1), (set 1, way 0), … Each dirty-valid entry → FLUSH_WB (same handshake as WRITEBACK) → clear dirty → continue the scan.
  - After the last entry → FLUSH_INV: clear all valid and LRU bits in one cycle, pulse flush_done, → IDLE.
  - A flush with no dirty lines takes NUM_SETS*WAYS + 1 cycles.
- LRU for WAYS=2: one bit per set pointing at the LRU way. For WAYS=1 the LRU bits are unused and constant 0.

Decomposition:
- dcache_pkg: FSM state enum; derived-width functions (OFF_W, IDX_W, TAG_W); byte-merge and word/byte-extract functions.
- One sub-module, dcache_way: tag/valid/dirty/data storage for one way, with a combinational hit output, line write port and byte/word merge port. Instantiated WAYS times via generate. The FSM, victim choice and LRU logic stay in data_cache_assoc.

Test Plan:
(Defaults: set 0 holds addresses 0x00, 0x40, 0x80; memory acks after 3 cycles.)
- Cold load 0x44, mem_rdata=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → exactly one refill with mem_addr=0x4 and mem_we=0. stall is high for 4 cycles, then readdata=0xBBBBBBBB. A repeat load of 0x48 returns 0xCCCCCCCC with no mem_req.
- Byte store 0x5A to 0x45 (hit) → no mem_req, stall=0. A word load of 0x44 returns 0xBBBB5ABB.
- Load 0x00 (refill into way 1), load 0x00 again, then load 0x80 → victim is the dirty 0x40 line. Expect a writeback with mem_addr=0x4 and mem_wdata containing 0xBBBB5ABB, then a refill with mem_addr=0x8. A following load of 0x00 hits.
- Two dirty lines (sets 0 and 2), pulse flush → exactly two writebacks in set order, one flush_done pulse, then a load of 0x00 misses. A flush with no dirty lines gives flush_done 9 cycles later with no mem_req.
- Assert reset while REFILL is waiting for mem_ack → mem_req=0 and stall=0 in the same cycle. After release, a load of 0x44 misses again.
- mem_ack held off for 10 cycles → mem_req, mem_addr and mem_we remain stable every cycle. A late ack seen while mem_req=0 has no effect.
